// File: rtl/multi_cycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath: sequences each instruction,
// drives datapath enables/selects, traps on illegal opcodes or memory timeouts.
module multi_cycle_ctrl #(
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [5:0]  opcode_i,
    input  logic [5:0]  funct_i,
    input  logic        zero_i,
    input  logic        mem_ready_i,
    output logic        pc_write_o,
    output logic        ir_write_o,
    output logic        reg_write_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic        iord_o,
    output logic        reg_dst_o,
    output logic        mem_to_reg_o,
    output logic        alu_src_a_o,
    output logic [1:0]  alu_src_b_o,
    output logic [2:0]  alu_op_o,
    output logic [1:0]  pc_src_o,
    output logic [3:0]  state_o,
    output logic        trap_o,
    output logic [31:0] retire_cnt_o
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_I_EXEC   = 4'd10,
        S_I_WB     = 4'd11,
        S_JR       = 4'd12,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [8:0] WAIT_LIMIT = 9'(MEM_WAIT_MAX);

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_wait;
    logic [31:0] r_retire;
    logic        r_trap;
    logic        w_retire;
    logic        w_mem_state;
    logic        w_timeout;
    logic        w_rtype_ok;

    always_comb begin
        w_mem_state = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
        // Ready in the limit cycle wins because the ready branch is taken before this.
        w_timeout   = w_mem_state && !mem_ready_i && (({1'b0, r_wait} + 9'd1) == WAIT_LIMIT);
        case (funct_i)
            6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: w_rtype_ok = 1'b1;
            default:                                               w_rtype_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_next   = r_state;
        w_retire = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (mem_ready_i)    w_next = S_DECODE;
                else if (w_timeout) w_next = S_TRAP;
            end
            S_DECODE: begin
                case (opcode_i)
                    OP_RTYPE: begin
                        if (funct_i == FN_JR) w_next = S_JR;
                        else if (w_rtype_ok)  w_next = S_R_EXEC;
                        else                  w_next = S_TRAP;
                    end
                    OP_ADDI, OP_SLTI: w_next = S_I_EXEC;
                    OP_LW, OP_SW:     w_next = S_MEM_ADDR;
                    OP_BEQ:           w_next = S_BRANCH;
                    OP_J:             w_next = S_JUMP;
                    default:          w_next = S_TRAP;
                endcase
            end
            S_MEM_ADDR: w_next = (opcode_i == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (mem_ready_i)    w_next = S_MEM_WB;
                else if (w_timeout) w_next = S_TRAP;
            end
            S_MEM_WR: begin
                if (mem_ready_i) begin
                    w_next   = S_FETCH;
                    w_retire = 1'b1;
                end else if (w_timeout) begin
                    w_next = S_TRAP;
                end
            end
            S_R_EXEC: w_next = S_R_WB;
            S_I_EXEC: w_next = S_I_WB;
            S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP, S_JR: begin
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_TRAP;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= S_FETCH;
            r_wait   <= '0;
            r_retire <= '0;
            r_trap   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_retire) r_retire <= r_retire + 32'd1;
            if (w_next == S_TRAP) r_trap <= 1'b1;
            // Any state change clears the count, which covers entry into a memory state.
            if (w_mem_state && !mem_ready_i && (w_next == r_state)) r_wait <= r_wait + 8'd1;
            else                                                    r_wait <= '0;
        end
    end

    always_comb begin
        pc_write_o   = 1'b0;
        ir_write_o   = 1'b0;
        reg_write_o  = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        iord_o       = 1'b0;
        reg_dst_o    = 1'b0;
        mem_to_reg_o = 1'b0;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = 2'b00;
        alu_op_o     = 3'b111;
        pc_src_o     = 2'b00;
        case (r_state)
            S_FETCH: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = 2'b01;
                pc_write_o  = mem_ready_i;
                ir_write_o  = mem_ready_i;
            end
            S_DECODE:   alu_src_b_o = 2'b11;
            S_MEM_ADDR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
            end
            S_MEM_RD: begin
                mem_read_o = 1'b1;
                iord_o     = 1'b1;
            end
            S_MEM_WB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
            end
            S_MEM_WR: begin
                mem_write_o = 1'b1;
                iord_o      = 1'b1;
            end
            S_R_EXEC: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = 3'b000;
            end
            S_R_WB: begin
                reg_write_o = 1'b1;
                reg_dst_o   = 1'b1;
            end
            S_I_EXEC: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
                alu_op_o    = (opcode_i == OP_SLTI) ? 3'b011 : 3'b010;
            end
            S_I_WB: reg_write_o = 1'b1;
            S_BRANCH: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = 3'b100;
                pc_src_o    = 2'b01;
                pc_write_o  = zero_i;
            end
            S_JUMP: begin
                pc_write_o = 1'b1;
                pc_src_o   = 2'b10;
            end
            S_JR: begin
                pc_write_o = 1'b1;
                pc_src_o   = 2'b11;
            end
            default: ;
        endcase
        if (rst_i) begin
            pc_write_o  = 1'b0;
            ir_write_o  = 1'b0;
            reg_write_o = 1'b0;
            mem_read_o  = 1'b0;
            mem_write_o = 1'b0;
        end
    end

    assign state_o      = r_state;
    assign trap_o       = r_trap;
    assign retire_cnt_o = r_retire;
endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Randomized bench for multi_cycle_ctrl: each instruction is expanded into the
// cycle-by-cycle behaviour the controller must show, then driven and compared.
module tb_multi_cycle_ctrl;
    localparam int unsigned MAX = 15;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [5:0]  opcode_i = '0;
    logic [5:0]  funct_i = '0;
    logic        zero_i = 1'b0;
    logic        mem_ready_i = 1'b0;
    logic        pc_write_o, ir_write_o, reg_write_o, mem_read_o, mem_write_o;
    logic        iord_o, reg_dst_o, mem_to_reg_o, alu_src_a_o;
    logic [1:0]  alu_src_b_o, pc_src_o;
    logic [2:0]  alu_op_o;
    logic [3:0]  state_o;
    logic        trap_o;
    logic [31:0] retire_cnt_o;

    multi_cycle_ctrl #(.MEM_WAIT_MAX(MAX)) dut (
        .clk_i(clk), .rst_i(rst_i), .opcode_i(opcode_i), .funct_i(funct_i),
        .zero_i(zero_i), .mem_ready_i(mem_ready_i),
        .pc_write_o(pc_write_o), .ir_write_o(ir_write_o), .reg_write_o(reg_write_o),
        .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .iord_o(iord_o),
        .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o), .alu_src_a_o(alu_src_a_o),
        .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o), .pc_src_o(pc_src_o),
        .state_o(state_o), .trap_o(trap_o), .retire_cnt_o(retire_cnt_o)
    );

    always #5 clk = ~clk;

    // en = {pc_write, ir_write, reg_write, mem_read, mem_write}
    // mx = {iord, reg_dst, mem_to_reg, alu_src_a, alu_src_b[1:0], alu_op[2:0], pc_src[1:0]}
    logic [4:0]  obs_en;
    logic [10:0] obs_mx;
    assign obs_en = {pc_write_o, ir_write_o, reg_write_o, mem_read_o, mem_write_o};
    assign obs_mx = {iord_o, reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o, alu_op_o, pc_src_o};

    localparam logic [10:0] MX_IDLE   = 11'b0_0_0_0_00_111_00;
    localparam logic [10:0] MX_FETCH  = 11'b0_0_0_0_01_111_00;
    localparam logic [10:0] MX_DEC    = 11'b0_0_0_0_11_111_00;
    localparam logic [10:0] MX_MADDR  = 11'b0_0_0_1_10_111_00;
    localparam logic [10:0] MX_MEMACC = 11'b1_0_0_0_00_111_00;
    localparam logic [10:0] MX_MWB    = 11'b0_0_1_0_00_111_00;
    localparam logic [10:0] MX_REX    = 11'b0_0_0_1_00_000_00;
    localparam logic [10:0] MX_RWB    = 11'b0_1_0_0_00_111_00;
    localparam logic [10:0] MX_ADDI   = 11'b0_0_0_1_10_010_00;
    localparam logic [10:0] MX_SLTI   = 11'b0_0_0_1_10_011_00;
    localparam logic [10:0] MX_BR     = 11'b0_0_0_1_00_100_01;
    localparam logic [10:0] MX_J      = 11'b0_0_0_0_00_111_10;
    localparam logic [10:0] MX_JR     = 11'b0_0_0_0_00_111_11;

    typedef struct {
        logic [3:0]  st;
        logic        rdy;
        logic        z;
        logic [4:0]  en;
        logic [10:0] mx;
    } exp_t;

    exp_t        q[$];
    logic [5:0]  rfn [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned exp_retire = 0;

    function automatic logic rb();
        return $urandom_range(0, 1) == 1;
    endfunction

    function automatic exp_t mk(input logic [3:0] st, input logic rdy, input logic z,
                                input logic [4:0] en, input logic [10:0] mx);
        exp_t e;
        e.st = st; e.rdy = rdy; e.z = z; e.en = en; e.mx = mx;
        return e;
    endfunction

    // A memory access that waits `waits` cycles; MAX waits without ready is a timeout.
    task automatic push_mem(input logic [3:0] st, input int unsigned waits, input logic [4:0] en_wait,
                            input logic [4:0] en_done, input logic [10:0] mx, output bit timed_out);
        timed_out = 1'b0;
        for (int unsigned i = 0; i < waits && i < MAX; i++) q.push_back(mk(st, 1'b0, rb(), en_wait, mx));
        if (waits >= MAX) begin
            timed_out = 1'b1;
            q.push_back(mk(4'd15, rb(), rb(), 5'b0, MX_IDLE));
        end else begin
            q.push_back(mk(st, 1'b1, rb(), en_done, mx));
        end
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int unsigned wf,
                             input int unsigned wm, input logic z, input int unsigned hold,
                             input int unsigned stop);
        bit to;
        bit trapped;
        int unsigned n;
        q.delete();
        trapped = 1'b0;
        push_mem(4'd0, wf, 5'b00010, 5'b11010, MX_FETCH, to);
        if (to) trapped = 1'b1;
        else begin
            q.push_back(mk(4'd1, rb(), rb(), 5'b0, MX_DEC));
            if (op == 6'h00 && fn == 6'h08) begin
                q.push_back(mk(4'd12, rb(), rb(), 5'b10000, MX_JR));
            end else if (op == 6'h00 && fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a}) begin
                q.push_back(mk(4'd6, rb(), rb(), 5'b0, MX_REX));
                q.push_back(mk(4'd7, rb(), rb(), 5'b00100, MX_RWB));
            end else if (op == 6'h08 || op == 6'h0a) begin
                q.push_back(mk(4'd10, rb(), rb(), 5'b0, (op == 6'h0a) ? MX_SLTI : MX_ADDI));
                q.push_back(mk(4'd11, rb(), rb(), 5'b00100, MX_IDLE));
            end else if (op == 6'h23) begin
                q.push_back(mk(4'd2, rb(), rb(), 5'b0, MX_MADDR));
                push_mem(4'd3, wm, 5'b00010, 5'b00010, MX_MEMACC, to);
                if (to) trapped = 1'b1;
                else    q.push_back(mk(4'd4, rb(), rb(), 5'b00100, MX_MWB));
            end else if (op == 6'h2b) begin
                q.push_back(mk(4'd2, rb(), rb(), 5'b0, MX_MADDR));
                push_mem(4'd5, wm, 5'b00001, 5'b00001, MX_MEMACC, to);
                trapped = to;
            end else if (op == 6'h04) begin
                q.push_back(mk(4'd8, rb(), z, {z, 4'b0}, MX_BR));
            end else if (op == 6'h02) begin
                q.push_back(mk(4'd9, rb(), rb(), 5'b10000, MX_J));
            end else begin
                trapped = 1'b1;
                q.push_back(mk(4'd15, rb(), rb(), 5'b0, MX_IDLE));
            end
        end
        if (trapped) for (int unsigned i = 0; i < hold; i++) q.push_back(mk(4'd15, rb(), rb(), 5'b0, MX_IDLE));
        n = (stop == 0) ? q.size() : stop;
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge clk);
            rst_i = 1'b0; opcode_i = op; funct_i = fn;
            mem_ready_i = q[i].rdy; zero_i = q[i].z;
            #1;
            n_checks++;
            if (state_o !== q[i].st) begin
                n_errors++;
                $display("FAIL state op=%h fn=%h cyc=%0d: got %0d exp %0d", op, fn, i, state_o, q[i].st);
            end
            n_checks++;
            if (obs_en !== q[i].en) begin
                n_errors++;
                $display("FAIL enables op=%h fn=%h cyc=%0d: got %b exp %b", op, fn, i, obs_en, q[i].en);
            end
            n_checks++;
            if (obs_mx !== q[i].mx) begin
                n_errors++;
                $display("FAIL selects op=%h fn=%h cyc=%0d: got %b exp %b", op, fn, i, obs_mx, q[i].mx);
            end
            n_checks++;
            if (trap_o !== (q[i].st == 4'd15)) begin
                n_errors++;
                $display("FAIL trap op=%h fn=%h cyc=%0d: got %b exp %b", op, fn, i, trap_o, q[i].st == 4'd15);
            end
            n_checks++;
            if (retire_cnt_o !== exp_retire) begin
                n_errors++;
                $display("FAIL retire op=%h fn=%h cyc=%0d: got %0d exp %0d", op, fn, i, retire_cnt_o, exp_retire);
            end
        end
        if (!trapped && stop == 0) exp_retire++;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_i = 1'b1; mem_ready_i = 1'b1; zero_i = 1'b1;
        #1;
        n_checks++;
        if (obs_en !== 5'b0) begin
            n_errors++;
            $display("FAIL reset_enables_first: got %b exp 00000", obs_en);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (state_o !== 4'd0) begin n_errors++; $display("FAIL reset_state: got %0d exp 0", state_o); end
        n_checks++;
        if (trap_o !== 1'b0) begin n_errors++; $display("FAIL reset_trap: got %b exp 0", trap_o); end
        n_checks++;
        if (retire_cnt_o !== 32'd0) begin n_errors++; $display("FAIL reset_retire: got %0d exp 0", retire_cnt_o); end
        n_checks++;
        if (obs_en !== 5'b0) begin n_errors++; $display("FAIL reset_enables: got %b exp 00000", obs_en); end
        exp_retire = 0;
    endtask

    task automatic test_rtype();
        run_instr(6'h00, 6'h20, 0, 0, 1'b0, 0, 0);
        run_instr(6'h00, 6'h2a, 1, 0, 1'b0, 0, 0);
    endtask

    task automatic test_lw_wait();
        run_instr(6'h23, 6'h11, 0, 3, 1'b0, 0, 0);
        run_instr(6'h2b, 6'h00, 2, 1, 1'b0, 0, 0);
    endtask

    task automatic test_branch();
        run_instr(6'h04, 6'h00, 0, 0, 1'b1, 0, 0);
        run_instr(6'h04, 6'h00, 0, 0, 1'b0, 0, 0);
    endtask

    task automatic test_itype_jr();
        run_instr(6'h08, 6'h3f, 0, 0, 1'b0, 0, 0);
        run_instr(6'h0a, 6'h00, 0, 0, 1'b0, 0, 0);
        run_instr(6'h00, 6'h08, 0, 0, 1'b0, 0, 0);
        run_instr(6'h02, 6'h00, 0, 0, 1'b0, 0, 0);
    endtask

    task automatic test_illegal_trap();
        run_instr(6'h3f, 6'h20, 0, 0, 1'b0, 100, 0);
        test_reset();
        run_instr(6'h00, 6'h01, 0, 0, 1'b0, 3, 0);
        test_reset();
        run_instr(6'h00, 6'h24, 0, 0, 1'b0, 0, 0);
    endtask

    task automatic test_fetch_timeout();
        run_instr(6'h00, 6'h25, MAX - 1, 0, 1'b0, 0, 0);
        run_instr(6'h00, 6'h25, MAX, 0, 1'b0, 5, 0);
        test_reset();
    endtask

    task automatic test_mem_timeout();
        run_instr(6'h2b, 6'h00, 0, MAX - 1, 1'b0, 0, 0);
        run_instr(6'h23, 6'h00, 0, MAX - 1, 1'b0, 0, 0);
        run_instr(6'h23, 6'h00, 0, MAX, 1'b0, 4, 0);
        test_reset();
        run_instr(6'h2b, 6'h00, 0, MAX, 1'b0, 4, 0);
        test_reset();
    endtask

    task automatic test_mid_reset();
        run_instr(6'h00, 6'h20, 0, 0, 1'b0, 0, 0);
        run_instr(6'h23, 6'h00, 0, 3, 1'b0, 0, 4);
        test_reset();
        run_instr(6'h2b, 6'h00, 0, 2, 1'b0, 0, 5);
        test_reset();
    endtask

    task automatic run_random(input int unsigned count, input bit with_waits);
        for (int unsigned k = 0; k < count; k++) begin
            logic [5:0] op;
            logic [5:0] fn;
            int unsigned wf, wm;
            fn = 6'($urandom);
            case ($urandom_range(0, 7))
                0: begin op = 6'h00; fn = rfn[$urandom_range(0, 4)]; end
                1: begin op = 6'h00; fn = 6'h08; end
                2: op = 6'h08;
                3: op = 6'h0a;
                4: op = 6'h23;
                5: op = 6'h2b;
                6: op = 6'h04;
                default: op = 6'h02;
            endcase
            wf = 0; wm = 0;
            if (with_waits) begin
                wf = ($urandom_range(0, 7) == 0) ? $urandom_range(0, MAX - 1) : $urandom_range(0, 2);
                wm = ($urandom_range(0, 7) == 0) ? $urandom_range(0, MAX - 1) : $urandom_range(0, 2);
            end
            run_instr(op, fn, wf, wm, rb(), 0, 0);
        end
    endtask

    task automatic test_back_to_back();
        run_random(30, 1'b0);
    endtask

    task automatic test_random();
        run_random(150, 1'b1);
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_wait();
        test_branch();
        test_itype_jr();
        test_back_to_back();
        test_illegal_trap();
        test_fetch_timeout();
        test_mem_timeout();
        test_mid_reset();
        test_random();
        test_reset();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
